// File: rtl/key_buzzer_beep_ctrl.sv
// Buzzer beep sequencer: each debounced key press plays a burst of BEEP_NUM tone beeps.
// Presses arriving mid-burst are queued (up to PEND_MAX) and played back to back.
module key_buzzer_beep_ctrl #(
  parameter logic [15:0] T1MS        = 16'd49_999,
  parameter logic [15:0] TONE_HALF   = 16'd12_499,
  parameter logic [15:0] BEEP_ON_MS  = 16'd100,
  parameter logic [15:0] BEEP_OFF_MS = 16'd100,
  parameter logic [3:0]  BEEP_NUM    = 4'd2,
  parameter logic [1:0]  PEND_MAX    = 2'd3
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Key_Pulse,
  input  logic Mute,
  output logic Buzzer_Out,
  output logic Busy,
  output logic Beep_Done
);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] cyc, ms, tcnt;
  logic [3:0]  beep_idx;
  logic [1:0]  pending, next_pending;
  logic        tone;
  logic        on_end, off_end;
  logic [2:0]  avail;

  assign on_end  = (ms == BEEP_ON_MS - 16'd1) && (cyc == T1MS);
  assign off_end = (ms == BEEP_OFF_MS - 16'd1) && (cyc == T1MS);

  // A press landing on the DONE cycle counts towards the queue, still capped at PEND_MAX
  always_comb begin
    avail = {1'b0, pending} + {2'b00, Key_Pulse};
    if (avail > {1'b0, PEND_MAX})
      avail = {1'b0, PEND_MAX};
  end

  always_comb begin
    next_state   = state;
    next_pending = pending;
    case (state)
      IDLE: begin
        if (Key_Pulse)
          next_state = ON;
      end
      ON: begin
        if (Key_Pulse && (pending < PEND_MAX))
          next_pending = pending + 2'd1;
        if (on_end)
          next_state = OFF;
      end
      OFF: begin
        if (Key_Pulse && (pending < PEND_MAX))
          next_pending = pending + 2'd1;
        if (off_end)
          next_state = (beep_idx < BEEP_NUM - 4'd1) ? ON : DONE;
      end
      DONE: begin
        if (avail != 3'd0) begin
          next_state   = ON;
          next_pending = avail[1:0] - 2'd1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      pending <= 2'd0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
    end
  end

  // Millisecond timebase restarts on every state entry, so each phase is counted from zero
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cyc <= 16'd0;
      ms  <= 16'd0;
    end else if ((next_state != state) || ((state != ON) && (state != OFF))) begin
      cyc <= 16'd0;
      ms  <= 16'd0;
    end else if (cyc == T1MS) begin
      cyc <= 16'd0;
      ms  <= ms + 16'd1;
    end else begin
      cyc <= cyc + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      beep_idx <= 4'd0;
    else if ((state == OFF) && (next_state == ON))
      beep_idx <= beep_idx + 4'd1;
    else if ((state == IDLE) || (state == DONE))
      beep_idx <= 4'd0;
  end

  // Tone starts high on every ON entry so each beep has the same waveform
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tone <= 1'b0;
      tcnt <= 16'd0;
    end else if (next_state != ON) begin
      tone <= 1'b0;
      tcnt <= 16'd0;
    end else if (state != ON) begin
      tone <= 1'b1;
      tcnt <= 16'd0;
    end else if (tcnt == TONE_HALF) begin
      tone <= ~tone;
      tcnt <= 16'd0;
    end else begin
      tcnt <= tcnt + 16'd1;
    end
  end

  assign Buzzer_Out = tone & ~Mute;
  assign Busy       = (state != IDLE);
  assign Beep_Done  = (state == DONE);

endmodule

// File: doc/key_buzzer_beep_ctrl.md
Name: key_buzzer_beep_ctrl

Overview:
Downstream consumer of the key debounce stage. Each single-cycle debounced key-press pulse triggers a burst of BEEP_NUM beeps. Each beep is a square-wave tone of BEEP_ON_MS ms, followed by BEEP_OFF_MS ms of silence. Presses that arrive during a burst are queued up to PEND_MAX deep, and the queued bursts play back to back. Buzzer_Out drives the board buzzer pin.

Parameters:
T1MS, 16'd49_999, clock cycles per ms minus 1 (50 MHz).
TONE_HALF, 16'd12_499, tone half-period in cycles minus 1 (2 kHz at 50 MHz).
BEEP_ON_MS, 16'd100, tone-on time per beep in ms (>=1).
BEEP_OFF_MS, 16'd100, silence after each beep in ms (>=1).
BEEP_NUM, 4'd2, beeps per burst (1..15).
PEND_MAX, 2'd3, max queued presses (0..3).

Ports:
CLK  input  1  system clock
RSTn  input  1  reset, asynchronous, active-low
Key_Pulse  input  1  one-cycle high pulse per debounced press, from the debounce stage
Mute  input  1  level; 1 forces Buzzer_Out low, sequencing continues
Buzzer_Out  output  1  tone square wave to buzzer
Busy  output  1  high whenever state != IDLE
Beep_Done  output  1  one-cycle pulse at the end of every burst

Behaviour:
- Reset values: state=IDLE; all counters 0; pending=0; tone=0; Buzzer_Out=0; Busy=0; Beep_Done=0. Reset applies immediately mid-burst and discards the queue.
- States: IDLE, ON, OFF, DONE. All outputs are registered or decoded from registered state only. No combinational path from Key_Pulse to any output.
- Timebase: cyc counts 0..T1MS in ON and OFF, then wraps. ms increments on wrap. Both counters clear on every state entry.
- IDLE: Key_Pulse=1 at edge k -> ON at k+1. beep_idx=0, pending unchanged.
- ON: lasts exactly BEEP_ON_MS*(T1MS+1) cycles. The exit condition is ms==BEEP_ON_MS-1 && cyc==T1MS, and it always goes to OFF.
- OFF: lasts exactly BEEP_OFF_MS*(T1MS+1) cycles, same exit form.
  - If beep_idx<BEEP_NUM-1: go to ON and increment beep_idx.
  - Otherwise: go to DONE.
- DONE: lasts one cycle with Beep_Done=1.
  - avail = pending + Key_Pulse, saturated at PEND_MAX.
  - If avail>0: go to ON with pending=avail-1 and beep_idx=0.
  - Otherwise: go to IDLE.
- Key_Pulse in ON or OFF: pending=min(pending+1, PEND_MAX). Presses beyond the limit are dropped silently. With PEND_MAX=0, all presses during a burst are dropped.
- Tone generator, on ON entry: tone=1, tcnt=0. Each ON cycle: if tcnt==TONE_HALF, toggle tone and clear tcnt; else increment tcnt. The output sequence is TONE_HALF+1 cycles high, then TONE_HALF+1 low, and so on. tone is forced to 0 outside ON.
- Buzzer_Out = tone & ~Mute. It is 0 in IDLE, OFF and DONE. Mute acts immediately and affects the output only.
- Full burst length from the first ON cycle to the last DONE cycle: BEEP_NUM*(BEEP_ON_MS+BEEP_OFF_MS)*(T1MS+1)+1 cycles.
- Counter widths: cyc, ms and tcnt are 16 bits; beep_idx is 4 bits; pending is 2 bits. No counter may wrap past its terminal value.

Test Plan (sim params T1MS=9, TONE_HALF=1, BEEP_ON_MS=3, BEEP_OFF_MS=2, BEEP_NUM=2, PEND_MAX=3):
- Single press: Key_Pulse at edge 10.
  - Busy rises at edge 11.
  - Buzzer_Out pattern 1,1,0,0 for 30 cycles (edges 11-40), then low for 20 cycles.
  - Second 30-cycle tone at edges 61-90, then low for 20 cycles.
  - Beep_Done high at edge 111 only; Busy falls at 112.
- Queue: 5 presses during the first burst.
  - pending saturates at 3.
  - Exactly 4 bursts play with no IDLE gap between them, giving 4 Beep_Done pulses 101 cycles apart.
  - Busy stays high throughout and falls 1 cycle after the 4th Beep_Done.
- Press coinciding with the DONE cycle, with pending=0: the next ON starts the following cycle, one extra burst plays, and pending ends at 0.
- Mute held high during the second beep:
  - Buzzer_Out stays 0 for edges 61-90.
  - Beep_Done timing is identical to the unmuted case (edge 111).
- RSTn pulsed low mid-ON with pending=2:
  - Buzzer_Out, Busy and Beep_Done go to 0 asynchronously.
  - After release there is no activity until a new Key_Pulse.
- PEND_MAX=0: 3 presses during a burst -> exactly one Beep_Done, then IDLE.
